// File: rtl/cmos_wr_burst.sv
// cmos_wr_burst: buffers CMOS camera pixels in an internal FIFO and hands them
// to a DDR3 write controller as address/length bursts, with a tail flush at
// the end of each frame.
// Optional build macro PING_PONG_EN: alternates the frame base address between
// BASE_ADDR and BASE_ADDR+FRAME_WORDS on every serviced frame start.
//
// Handshake: wr_burst_req rises when a burst is ready and stays high, with
// wr_burst_addr/wr_burst_len stable, until the controller pulses wr_burst_ack
// for one cycle. After that the controller pops exactly wr_burst_len words by
// asserting wr_data_req (one word per cycle it is high); each popped word
// appears on wr_data in the following cycle.
module cmos_wr_burst #(
  parameter int          BURST_LEN   = 64,
  parameter int          FRAME_WORDS = 786432,
  parameter int          FIFO_DEPTH  = 512,
  parameter logic [27:0] BASE_ADDR   = 28'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  output logic        wr_burst_req,
  input  logic        wr_burst_ack,
  output logic [27:0] wr_burst_addr,
  output logic [8:0]  wr_burst_len,
  input  logic        wr_data_req,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(FRAME_WORDS + 1);
  localparam int TW = (PW > 9) ? PW : 9;
  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] FW_C    = PW'(FRAME_WORDS);
  localparam logic [TW-1:0] FW_T    = TW'(FRAME_WORDS);
  localparam logic [27:0]   FW_A    = 28'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_XFER = 2'd2} state_t;

  state_t        state_q;
  logic          vsync_d1_q;
  logic          armed_q, armed_d;
  logic          pend_q, pend_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic          buf_sel_q, buf_sel_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [15:0]   wr_data_q;
  logic          req_q, done_q;
  logic [27:0]   addr_q;
  logic [8:0]    len_q, xfer_cnt_q;
  logic [TW-1:0] wr_total_q, wr_total_nxt;
  logic          rise, service, pixel_in, fifo_full, push, pop;
  logic          start_full, start_tail, last_pop;
  logic [27:0]   frame_base;

  // A frame start is serviced only in IDLE; one arriving mid-burst waits in pend_q.
  assign rise       = frame_vsync & ~vsync_d1_q;
  assign service    = (state_q == S_IDLE) && (rise || pend_q);
  assign pixel_in   = frame_valid && armed_q && !pend_q && !rise && (pix_cnt_q < FW_C);
  assign fifo_full  = (count_q == DEPTH_C);
  assign push       = pixel_in && !fifo_full;
  assign pop        = (state_q == S_XFER) && wr_data_req && (count_q != '0);
  assign start_full = (count_q >= BL_C);
  assign start_tail = (pix_cnt_q == FW_C) && (count_q != '0) && (count_q < BL_C);
  assign last_pop   = (state_q == S_XFER) && wr_data_req && ((xfer_cnt_q + 9'd1) == len_q);
  assign wr_total_nxt = wr_total_q + TW'(len_q);
  assign frame_base = buf_sel_q ? (BASE_ADDR + FW_A) : BASE_ADDR;

  assign wr_burst_req  = req_q;
  assign wr_burst_addr = addr_q;
  assign wr_burst_len  = len_q;
  assign wr_data       = wr_data_q;
  assign frame_done    = done_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;
  assign dbg_state     = state_q;

  // Next-state for FIFO pointers, pixel counter, arming and sticky flags.
  always_comb begin
    armed_d     = armed_q;
    pend_d      = pend_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    buf_sel_d   = buf_sel_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pix_cnt_d   = pix_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pixel_in) pix_cnt_d = pix_cnt_q + PW'(1);
    if (pixel_in && fifo_full) overflow_d = 1'b1;
    if (rise && (state_q != S_IDLE)) begin
      pend_d      = 1'b1;
      frame_err_d = 1'b1;
    end
    if (service) begin
      armed_d    = 1'b1;
      pend_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pix_cnt_d  = '0;
      overflow_d = 1'b0;
      // The start that caused the error keeps the flag; a clean start clears it.
      if (!pend_q) frame_err_d = 1'b0;
`ifdef PING_PONG_EN
      buf_sel_d = ~buf_sel_q;
`else
      buf_sel_d = 1'b0;
`endif
    end
  end

  // Datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q  <= 1'b0;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      buf_sel_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pix_cnt_q   <= '0;
    end else begin
      vsync_d1_q  <= frame_vsync;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      buf_sel_q   <= buf_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  // FIFO storage write port (contents need no reset; pointers define validity).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= frame_data;
  end

  // Registered read port: popped word is presented the cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   wr_data_q <= '0;
    else if (pop) wr_data_q <= mem[rd_ptr_q];
  end

  // Burst FSM IDLE->REQ->XFER->IDLE with registered request, address, length and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      len_q      <= '0;
      xfer_cnt_q <= '0;
      done_q     <= 1'b0;
      wr_total_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (service) begin
            addr_q     <= frame_base;
            wr_total_q <= '0;
          end else if (start_full) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            len_q   <= 9'(BURST_LEN);
          end else if (start_tail) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            len_q   <= 9'(count_q);
          end
        end
        S_REQ: begin
          if (wr_burst_ack) begin
            state_q    <= S_XFER;
            req_q      <= 1'b0;
            xfer_cnt_q <= '0;
          end
        end
        S_XFER: begin
          if (last_pop) begin
            state_q    <= S_IDLE;
            addr_q     <= addr_q + 28'(len_q);
            wr_total_q <= wr_total_nxt;
            if (wr_total_nxt == FW_T) done_q <= 1'b1;
          end else if (wr_data_req) begin
            xfer_cnt_q <= xfer_cnt_q + 9'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
